// File: rtl/config_uart_pkg.sv
// rtl/config_uart_pkg.sv - shared types and helpers for the config UART transmitter/receiver
//
// Purpose : line state encoding, word geometry and baud divisor helper used by both
//           directions of the configuration UART.
// Ports   : none (package).

package config_uart_pkg;

    // Framing states of one 8N1 character; IDLE is the between-words state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Data bytes carried by one 32-bit configuration word.
    localparam int unsigned BYTES_PER_WORD = 4;

    // Bits per UART character payload.
    localparam int unsigned BITS_PER_BYTE = 8;

    // Clock cycles per line bit, truncating; callers require a result of at least 2.
    function automatic int unsigned clks_per_bit(input int unsigned clock_frequency,
                                                 input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period tick generator for the config UART
//
// Purpose : free-running modulo-CLKS_PER_BIT counter producing a one-cycle tick on the
//           last cycle of every bit period; a synchronous restart realigns the period.
// Ports   : clk_i      in  1  clock, rising edge
//           rst_ni     in  1  asynchronous active-low reset
//           restart_i  in  1  force the counter to 0 on the next edge
//           tick_o     out 1  high in the final cycle of each bit period

module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/config_uart_tx.sv
// rtl/config_uart_tx.sv - config port return path: 32-bit word to 8N1 UART byte stream
//
// Purpose : accepts a status/readback word and sends it MSB byte first, each byte as
//           start bit, 8 data bits LSB first, stop bit. Build option
//           CONFIG_UART_TX_CHECKSUM_EN appends a fifth byte, the XOR of the four data bytes.
// Ports   : CLK          in  1   clock, rising edge
//           resetn       in  1   asynchronous active-low reset
//           TxData       in  32  word to send, captured on acceptance
//           TxValid      in  1   TxData valid
//           TxReady      out 1   word can be accepted this cycle
//           Tx           out 1   serial line, idle high, registered
//           TxActive     out 1   word in flight
//           TransmitLED  out 1   toggles per accepted word

module config_uart_tx
    import config_uart_pkg::*;
#(
    parameter int unsigned UART_BAUD_RATE  = 115_200,
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [31:0] TxData,
    input  logic        TxValid,
    output logic        TxReady,
    output logic        Tx,
    output logic        TxActive,
    output logic        TransmitLED
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);

`ifdef CONFIG_UART_TX_CHECKSUM_EN
    localparam int unsigned NUM_BYTES = BYTES_PER_WORD + 1;
`else
    localparam int unsigned NUM_BYTES = BYTES_PER_WORD;
`endif

    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    uart_state_e state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        led_q, led_d;

    logic        tick;
    logic        restart;
    logic        accept;
    logic [7:0]  cur_byte;
    logic [2:0]  nxt_bit;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (CLK),
        .rst_ni   (resetn),
        .restart_i(restart),
        .tick_o   (tick)
    );

    assign TxReady     = (state_q == ST_IDLE);
    assign TxActive    = (state_q != ST_IDLE);
    assign Tx          = tx_q;
    assign TransmitLED = led_q;
    assign accept      = TxValid && (state_q == ST_IDLE);
    assign nxt_bit     = bit_idx_q + 3'd1;

`ifdef CONFIG_UART_TX_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
`endif

    // Byte currently on the line, most significant byte of the word first.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_q)
            3'd0:    cur_byte = word_q[31:24];
            3'd1:    cur_byte = word_q[23:16];
            3'd2:    cur_byte = word_q[15:8];
            3'd3:    cur_byte = word_q[7:0];
`ifdef CONFIG_UART_TX_CHECKSUM_EN
            3'd4:    cur_byte = checksum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // tx_d is the line level for the state being entered, so Tx changes exactly
    // on the edge that changes state and never glitches.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        led_d      = led_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    word_d     = TxData;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    led_d      = ~led_q;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = nxt_bit;
                        tx_d      = cur_byte[nxt_bit];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    bit_idx_d = 3'd0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = ST_START;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Realign the bit period on every state change; holding it in restart while idle
    // makes the first start bit a full period regardless of when the word arrives.
    assign restart = (state_d != state_q) || (state_q == ST_IDLE);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            led_q      <= led_d;
        end
    end

endmodule

// File: tb/tb_config_uart_tx.sv
// tb/tb_config_uart_tx.sv - scoreboard bench for config_uart_tx

module tb_config_uart_tx;

    localparam int CPB = 8;
`ifdef CONFIG_UART_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int LINE_CYC = NB * 10 * CPB;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] TxData = 32'h0;
    logic        TxValid = 1'b0;
    logic        TxReady;
    logic        Tx;
    logic        TxActive;
    logic        TransmitLED;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        led_model = 1'b0;
    logic [7:0]  exp_q[$];

    config_uart_tx #(
        .UART_BAUD_RATE (1),
        .CLOCK_FREQUENCY(8)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .Tx         (Tx),
        .TxActive   (TxActive),
        .TransmitLED(TransmitLED)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`ifdef CONFIG_UART_TX_CHECKSUM_EN
        exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    endtask

    // Presents w and waits for acceptance; acc is the accept cycle index.
    task automatic send(input logic [31:0] w, input bit keep, output int acc);
        int n;
        n = 0;
        @(negedge CLK);
        TxData  = w;
        TxValid = 1'b1;
        while (!TxReady && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("accept_timeout", 32'(TxReady), 32'd1);
        acc = cyc;
        push_word(w);
        led_model = ~led_model;
        if (!keep) begin
            @(negedge CLK);
            TxValid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (TxActive && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(TxActive), 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_n(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (!resetn) ab = 1'b1;
        end
    endtask

    // Line monitor: decodes 8N1 at mid-bit and compares against the scoreboard.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        bit         ab;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (!resetn) begin
                exp_q.delete();
                prev = 1'b1;
            end else if (prev === 1'b1 && Tx === 1'b0) begin
                ab = 1'b0;
                b  = 8'h00;
                wait_n(CPB / 2, ab);
                if (!ab) check("start_bit", 32'(Tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        wait_n(CPB, ab);
                        b[i] = Tx;
                    end
                end
                if (!ab) wait_n(CPB, ab);
                if (ab) begin
                    exp_q.delete();
                    prev = 1'b1;
                end else begin
                    check("stop_bit", 32'(Tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e));
                    end
                    prev = Tx;
                end
            end else begin
                prev = Tx;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int n;

        // 1. reset state, during and after reset
        repeat (3) @(negedge CLK);
        check("rst_tx", 32'(Tx), 32'd1);
        check("rst_ready", 32'(TxReady), 32'd1);
        check("rst_active", 32'(TxActive), 32'd0);
        check("rst_led", 32'(TransmitLED), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_tx", 32'(Tx), 32'd1);
        check("post_rst_ready", 32'(TxReady), 32'd1);

        // 2. single word, latency and ready return
        send(32'hA5C3_0F81, 1'b0, a1);
        check("tx_fall_latency", 32'(Tx), 32'd0);
        check("busy_ready", 32'(TxReady), 32'd0);
        check("busy_active", 32'(TxActive), 32'd1);
        n = 0;
        while (!TxReady && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("ready_return", 32'(cyc - (a1 + 1)), 32'(LINE_CYC));
        check("led_word1", 32'(TransmitLED), 32'(led_model));
        wait_idle();

        // 3. back-to-back with TxValid held
        send(32'h1357_9BDF, 1'b1, a1);
        send(32'hFEDC_BA98, 1'b0, a2);
        check("b2b_period", 32'(a2 - a1), 32'(LINE_CYC + 1));
        wait_idle();
        check("led_b2b", 32'(TransmitLED), 32'(led_model));

        // 4. TxValid pulse with new data while busy is ignored
        send(32'h3C69_DE00, 1'b0, a1);
        repeat (100) @(negedge CLK);
        TxData  = 32'hDEAD_BEEF;
        TxValid = 1'b1;
        @(negedge CLK);
        TxValid = 1'b0;
        check("busy_ignore_ready", 32'(TxReady), 32'd0);
        wait_idle();
        check("led_ignore", 32'(TransmitLED), 32'(led_model));

        // 5. reset during data bit 1 of byte 2, then a clean word
        send(32'h5A00_FF77, 1'b0, a1);
        repeat (98) @(negedge CLK);
        check("pre_abort_tx", 32'(Tx), 32'd0);
        resetn = 1'b0;
        #1;
        check("abort_tx", 32'(Tx), 32'd1);
        check("abort_ready", 32'(TxReady), 32'd1);
        check("abort_active", 32'(TxActive), 32'd0);
        check("abort_led", 32'(TransmitLED), 32'd0);
        led_model = 1'b0;
        repeat (4) @(negedge CLK);
        resetn = 1'b1;
        repeat (3) @(negedge CLK);
        send(32'h1234_5678, 1'b0, a1);
        wait_idle();
        check("led_after_abort", 32'(TransmitLED), 32'(led_model));

        // 6. checksum vector, back-to-back for the word period
        send(32'h0102_0304, 1'b1, a1);
        send(32'h0102_0304, 1'b0, a2);
        check("cks_period", 32'(a2 - a1), 32'(LINE_CYC + 1));
        wait_idle();

        repeat (20) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
